// File: rtl/mux_2x1_rr_arbiter_if.sv
// Handshake bundle shared by the two requesters, the round-robin arbiter and
// the downstream consumer; the arbiter takes the slave view.
interface mux_2x1_rr_arbiter_if #(
    parameter int W = 8
);
    logic         in0_valid;
    logic [W-1:0] in0_data;
    logic         in0_last;
    logic         in0_ready;

    logic         in1_valid;
    logic [W-1:0] in1_data;
    logic         in1_last;
    logic         in1_ready;

    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_src;
    logic         out_ready;

    logic         sel;

    modport slave (
        input  in0_valid, in0_data, in0_last,
        output in0_ready,
        input  in1_valid, in1_data, in1_last,
        output in1_ready,
        output out_valid, out_data, out_last, out_src,
        input  out_ready,
        output sel
    );

    modport master (
        output in0_valid, in0_data, in0_last,
        input  in0_ready,
        output in1_valid, in1_data, in1_last,
        input  in1_ready,
        input  out_valid, out_data, out_last, out_src,
        output out_ready,
        input  sel
    );
endinterface

// File: rtl/mux_2x1_rr_arbiter.sv
// Round-robin burst arbiter for a 2:1 mux: locks a grant until last or a beat
// timeout, drives the mux select and registers accepted beats in one output slot.
module mux_2x1_rr_arbiter #(
    parameter int W         = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_2x1_rr_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY0,
        BUSY1
    } state_t;

    state_t        state;
    logic          prio;
    logic [CW-1:0] cnt;
    logic          sel_q;

    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic          out_last_q;
    logic          out_src_q;

    logic          can_accept;
    logic          grant1;
    logic          cur_valid;
    logic [W-1:0]  cur_data;
    logic          cur_last;
    logic          xfer;
    logic          burst_end;

    // Readies depend only on state and the output slot, never on requester valids.
    assign can_accept    = !out_valid_q || bus.out_ready;
    assign bus.in0_ready = (state == BUSY0) && can_accept;
    assign bus.in1_ready = (state == BUSY1) && can_accept;

    assign grant1    = (state == BUSY1);
    assign cur_valid = grant1 ? bus.in1_valid : bus.in0_valid;
    assign cur_data  = grant1 ? bus.in1_data  : bus.in0_data;
    assign cur_last  = grant1 ? bus.in1_last  : bus.in0_last;
    assign xfer      = cur_valid && (bus.in0_ready || bus.in1_ready);

    // cnt still holds the pre-increment count, so MAX_BEATS-1 marks the final allowed beat.
    assign burst_end = cur_last || (cnt == CW'(MAX_BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prio        <= 1'b0;
            cnt         <= '0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in0_valid && bus.in1_valid) begin
                        state <= prio ? BUSY1 : BUSY0;
                        sel_q <= prio;
                    end else if (bus.in0_valid) begin
                        state <= BUSY0;
                        sel_q <= 1'b0;
                    end else if (bus.in1_valid) begin
                        state <= BUSY1;
                        sel_q <= 1'b1;
                    end
                end
                BUSY0, BUSY1: begin
                    if (xfer) begin
                        if (burst_end) begin
                            state <= IDLE;
                            prio  <= ~grant1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A new beat may overwrite the slot in the same cycle the old one drains.
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= cur_data;
                out_last_q  <= cur_last;
                out_src_q   <= grant1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
    assign bus.sel       = sel_q;
endmodule

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Scoreboard bench for mux_2x1_rr_arbiter: a transaction-level round-robin model
// predicts the output beat order; a monitor pops and compares each output handshake.
module tb_mux_2x1_rr_arbiter;
    localparam int W         = 8;
    localparam int MAX_BEATS = 4;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           gap;
    } beat_t;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic         src;
    } exp_t;

    logic clk;
    logic rst;

    mux_2x1_rr_arbiter_if #(.W(W)) bus ();

    mux_2x1_rr_arbiter #(.W(W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t q0[$];
    beat_t q1[$];
    exp_t  exp_q[$];
    int    hs_cycle[$];
    logic  hs_src[$];
    logic  hs_sel[$];

    int    check_count = 0;
    int    pass_count  = 0;
    int    cyc         = 0;
    logic  model_prio;
    logic  abort;
    logic  done0;
    logic  done1;
    logic  rdy_rand;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: sim time %0t, required finish before 500000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    function automatic void add_beat(input int r, input logic [W-1:0] d, input logic l, input int gap);
        beat_t b;
        b.data = d;
        b.last = l;
        b.gap  = gap;
        if (r == 0) q0.push_back(b);
        else q1.push_back(b);
    endfunction

    function automatic void push_exp(input logic [W-1:0] d, input logic l, input logic s);
        exp_t e;
        e.data = d;
        e.last = l;
        e.src  = s;
        exp_q.push_back(e);
    endfunction

    // Grants go whole-burst at a time, capped at MAX_BEATS, alternating when both wait.
    function automatic void model_expect();
        beat_t m0[$];
        beat_t m1[$];
        beat_t b;
        logic  g;
        int    n;
        bit    stop;
        m0 = q0;
        m1 = q1;
        while (m0.size() > 0 || m1.size() > 0) begin
            if (m0.size() > 0 && m1.size() > 0) g = model_prio;
            else g = (m1.size() > 0);
            n = 0;
            stop = 0;
            while (!stop) begin
                if (g) b = m1.pop_front();
                else b = m0.pop_front();
                push_exp(b.data, b.last, g);
                n++;
                if (b.last || n == MAX_BEATS) begin
                    stop = 1;
                    model_prio = !g;
                end else if ((g ? m1.size() : m0.size()) == 0) begin
                    stop = 1;
                end
            end
        end
    endfunction

    task automatic set_req(input int r, input logic v, input logic [W-1:0] d, input logic l);
        if (r == 0) begin
            bus.in0_valid = v;
            bus.in0_data  = d;
            bus.in0_last  = l;
        end else begin
            bus.in1_valid = v;
            bus.in1_data  = d;
            bus.in1_last  = l;
        end
    endtask

    // Valid only drops mid-grant, so arbitration always sees every requester with work.
    task automatic drive_req(input int r, input int delay);
        beat_t b;
        int    chunk;
        int    budget;
        logic  got;
        logic  rdy;
        chunk = 0;
        set_req(r, 1'b0, '0, 1'b0);
        repeat (delay) @(negedge clk);
        while (((r == 0) ? q0.size() : q1.size()) > 0 && !abort) begin
            b = (r == 0) ? q0[0] : q1[0];
            if (b.gap > 0 && chunk != 0) begin
                set_req(r, 1'b0, '0, 1'b0);
                repeat (b.gap) @(negedge clk);
            end
            set_req(r, 1'b1, b.data, b.last);
            got = 1'b0;
            budget = 0;
            while (!got && !abort && budget <= 1000) begin
                #2;
                rdy = (r == 0) ? bus.in0_ready : bus.in1_ready;
                if (rdy) got = 1'b1;
                @(negedge clk);
                budget++;
            end
            if (!got && !abort) begin
                checkOutput("req_accept", 32'(got), 1);
                if (r == 0) q0.delete();
                else q1.delete();
            end else if (got) begin
                if (r == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                chunk++;
                if (b.last || chunk == MAX_BEATS) chunk = 0;
            end
        end
        set_req(r, 1'b0, '0, 1'b0);
        if (r == 0) done0 = 1'b1;
        else done1 = 1'b1;
    endtask

    task automatic applyStimulus(input int d0, input int d1);
        done0 = 1'b0;
        done1 = 1'b0;
        fork
            drive_req(0, d0);
            drive_req(1, d1);
        join
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(exp_q.size()), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        checkOutput({tag, "_out_data"},  32'(bus.out_data),  0);
        checkOutput({tag, "_out_last"},  32'(bus.out_last),  0);
        checkOutput({tag, "_out_src"},   32'(bus.out_src),   0);
        checkOutput({tag, "_sel"},       32'(bus.sel),       0);
        checkOutput({tag, "_in0_ready"}, 32'(bus.in0_ready), 0);
        checkOutput({tag, "_in1_ready"}, 32'(bus.in1_ready), 0);
    endtask

    task automatic reset_mid_burst_script();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (!bus.out_valid && n < 20);
        checkOutput("pre_reset_out_valid", 32'(bus.out_valid), 1);
        checkOutput("pre_reset_out_src",   32'(bus.out_src),   1);
        checkOutput("pre_reset_sel",       32'(bus.sel),       1);
        rst = 1'b1;
        abort = 1'b1;
        #1;
        check_reset_outputs("async_reset");
    endtask

    task automatic backpressure_script();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (!bus.out_valid && n < 20);
        checkOutput("bp_first_valid", 32'(bus.out_valid), 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_hold_data", 32'(bus.out_data),  32'h0C1);
            checkOutput("bp_in0_ready", 32'(bus.in0_ready), 0);
            checkOutput("bp_in1_ready", 32'(bus.in1_ready), 0);
            if (i < 2) begin
                @(negedge clk);
                #3;
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #3;
        checkOutput("bp_same_cycle_accept", 32'(bus.in0_ready), 1);
        @(negedge clk);
        #3;
        checkOutput("bp_no_bubble_valid", 32'(bus.out_valid), 1);
        checkOutput("bp_next_data",       32'(bus.out_data),  32'h0C2);
    endtask

    task automatic gap_script();
        int n;
        int viol;
        n = 0;
        viol = 0;
        while (!done1 && n < 200) begin
            @(negedge clk);
            #3;
            if (bus.in0_ready) viol++;
            n++;
        end
        checkOutput("gap_in0_ready_early", 32'(viol), 0);
    endtask

    initial begin : out_ready_gen
        forever begin
            @(negedge clk);
            if (rdy_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: scoreboard pops, held-beat stability and ready/select consistency.
    initial begin : monitor
        logic         prev_hold;
        logic [W-1:0] pd;
        logic         pl;
        logic         ps;
        exp_t         e;
        prev_hold = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    checkOutput("hold_valid", 32'(bus.out_valid), 1);
                    checkOutput("hold_beat", {22'd0, bus.out_data, bus.out_last, bus.out_src}, {22'd0, pd, pl, ps});
                end
                if (bus.in0_ready || bus.in1_ready) begin
                    checkOutput("ready_onehot", 32'(bus.in0_ready && bus.in1_ready), 0);
                    checkOutput("ready_sel", 32'(bus.sel), 32'(bus.in1_ready));
                    checkOutput("ready_while_stalled", 32'(bus.out_valid && !bus.out_ready), 0);
                end
                if (bus.out_valid && bus.out_ready) begin
                    hs_cycle.push_back(cyc);
                    hs_src.push_back(bus.out_src);
                    hs_sel.push_back(bus.sel);
                    if (exp_q.size() == 0) begin
                        checkOutput("beat_expected", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat_data", 32'(bus.out_data), 32'(e.data));
                        checkOutput("beat_last", 32'(bus.out_last), 32'(e.last));
                        checkOutput("beat_src",  32'(bus.out_src),  32'(e.src));
                    end
                end
                prev_hold = bus.out_valid && !bus.out_ready;
                pd = bus.out_data;
                pl = bus.out_last;
                ps = bus.out_src;
            end
        end
    end

    initial begin : stim
        int nb;
        int len;
        rst        = 1'b1;
        abort      = 1'b0;
        rdy_rand   = 1'b0;
        model_prio = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        set_req(0, 1'b0, '0, 1'b0);
        set_req(1, 1'b0, '0, 1'b0);
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        #3;
        check_reset_outputs("init_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Asynchronous reset while requester 1 has a beat stuck in the output slot.
        add_beat(1, 8'h51, 1'b0, 0);
        add_beat(1, 8'h52, 1'b0, 0);
        add_beat(1, 8'h53, 1'b1, 0);
        bus.out_ready = 1'b0;
        fork
            applyStimulus(0, 0);
            reset_mid_burst_script();
        join
        q0.delete();
        q1.delete();
        abort = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_prio = 1'b0;
        @(negedge clk);

        // Simultaneous two-beat bursts right after reset: priority 0 first, one idle gap.
        add_beat(0, 8'hA1, 1'b0, 0);
        add_beat(0, 8'hA2, 1'b1, 0);
        add_beat(1, 8'hB1, 1'b0, 0);
        add_beat(1, 8'hB2, 1'b1, 0);
        model_expect();
        bus.out_ready = 1'b1;
        hs_cycle.delete();
        hs_src.delete();
        hs_sel.delete();
        applyStimulus(0, 0);
        wait_drain();
        checkOutput("sim_hs_count", 32'(hs_cycle.size()), 4);
        if (hs_cycle.size() == 4) begin
            checkOutput("sim_gap_a1_a2", 32'(hs_cycle[1] - hs_cycle[0]), 1);
            checkOutput("sim_gap_a2_b1", 32'(hs_cycle[2] - hs_cycle[1]), 2);
            checkOutput("sim_gap_b1_b2", 32'(hs_cycle[3] - hs_cycle[2]), 1);
            checkOutput("sim_sel_a", 32'(hs_sel[0]), 0);
            checkOutput("sim_sel_b", 32'(hs_sel[2]), 1);
        end

        // Single-beat bursts from both sides must alternate sources.
        for (int i = 0; i < 4; i++) begin
            add_beat(0, 8'(8'h10 + i), 1'b1, 0);
            add_beat(1, 8'(8'h20 + i), 1'b1, 0);
        end
        model_expect();
        hs_src.delete();
        applyStimulus(0, 0);
        wait_drain();
        checkOutput("rr_hs_count", 32'(hs_src.size()), 8);
        if (hs_src.size() == 8) begin
            for (int i = 0; i < 8; i++) checkOutput("rr_alternate", 32'(hs_src[i]), 32'(i % 2));
        end

        // Downstream stall of three cycles, then a same-cycle refill.
        add_beat(0, 8'hC1, 1'b0, 0);
        add_beat(0, 8'hC2, 1'b0, 0);
        add_beat(0, 8'hC3, 1'b1, 0);
        model_expect();
        bus.out_ready = 1'b0;
        fork
            applyStimulus(0, 0);
            backpressure_script();
        join
        wait_drain();

        // Randomized bursts, valid gaps and downstream backpressure.
        rdy_rand = 1'b1;
        for (int p = 0; p < 25; p++) begin
            for (int r = 0; r < 2; r++) begin
                nb = $urandom_range(0, 3);
                for (int bi = 0; bi < nb; bi++) begin
                    len = $urandom_range(1, 6);
                    for (int k = 0; k < len; k++) begin
                        add_beat(r, 8'($urandom), (k == len - 1),
                                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
                    end
                end
            end
            model_expect();
            applyStimulus(0, 0);
            wait_drain();
        end
        rdy_rand = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;

        // Requester 1 owns the grant and pauses mid-burst; requester 0 must wait.
        add_beat(1, 8'h61, 1'b0, 0);
        add_beat(1, 8'h62, 1'b0, 2);
        add_beat(1, 8'h63, 1'b1, 0);
        add_beat(0, 8'h71, 1'b0, 0);
        add_beat(0, 8'h72, 1'b1, 0);
        push_exp(8'h61, 1'b0, 1'b1);
        push_exp(8'h62, 1'b0, 1'b1);
        push_exp(8'h63, 1'b1, 1'b1);
        push_exp(8'h71, 1'b0, 1'b0);
        push_exp(8'h72, 1'b1, 1'b0);
        fork
            applyStimulus(1, 0);
            gap_script();
        join
        wait_drain();

        // Six unterminated beats from requester 0: forced release after four.
        for (int i = 1; i <= 6; i++) add_beat(0, 8'(8'hE0 + i), 1'b0, 0);
        add_beat(1, 8'hF1, 1'b0, 0);
        add_beat(1, 8'hF2, 1'b1, 0);
        for (int i = 1; i <= 4; i++) push_exp(8'(8'hE0 + i), 1'b0, 1'b0);
        push_exp(8'hF1, 1'b0, 1'b1);
        push_exp(8'hF2, 1'b1, 1'b1);
        push_exp(8'hE5, 1'b0, 1'b0);
        push_exp(8'hE6, 1'b0, 1'b0);
        applyStimulus(0, 1);
        wait_drain();

        // Requester 0 still owns the grant; reset clears it and priority returns to 0.
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("final_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_prio = 1'b0;
        @(negedge clk);
        add_beat(0, 8'h91, 1'b1, 0);
        add_beat(1, 8'h92, 1'b1, 0);
        model_expect();
        applyStimulus(0, 0);
        wait_drain();

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
